// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard controller for a 5-stage pipeline.
// Detects load-use and branch-operand hazards, inserts one or two bubbles
// through a two-state stall FSM, and squashes the fetched instruction when a
// branch resolved in ID is taken.
// Optional build macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_unit #(
  parameter int rwidth = 5
`ifdef HAZARD_STATS_EN
  ,
  parameter int cwidth = 32
`endif
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [rwidth-1:0] IF_ID_RegisterRs,
  input  logic [rwidth-1:0] IF_ID_RegisterRt,
  input  logic              ID_Branch,
  input  logic              ID_Branch_Taken,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_RegDst,
  input  logic [rwidth-1:0] ID_EX_RegisterRt,
  input  logic [rwidth-1:0] ID_EX_RegisterRd,
  input  logic              EX_MEM_MemRead,
  input  logic [rwidth-1:0] EX_MEM_RegisterRd,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              Stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [cwidth-1:0] Stall_Count,
  output logic [cwidth-1:0] Flush_Count
`endif
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t state, state_next;

  logic [rwidth-1:0] ex_dst;
  logic              h_lu;
  logic              h_ba;
  logic              h_bm;
  logic              need_two;
  logic              need_one;
  logic              branch_squash;

  // Destination of the instruction in EX depends on its RegDst control bit.
  assign ex_dst = ID_EX_RegDst ? ID_EX_RegisterRd : ID_EX_RegisterRt;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  assign h_lu = ID_EX_MemRead && (ID_EX_RegisterRt != '0) &&
                ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (ID_EX_RegisterRt == IF_ID_RegisterRt));

  assign h_ba = ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && (ex_dst != '0) &&
                ((ex_dst == IF_ID_RegisterRs) || (ex_dst == IF_ID_RegisterRt));

  assign h_bm = ID_Branch && EX_MEM_MemRead && (EX_MEM_RegisterRd != '0) &&
                ((EX_MEM_RegisterRd == IF_ID_RegisterRs) || (EX_MEM_RegisterRd == IF_ID_RegisterRt));

  // A branch waiting on a load still in EX needs the loaded value in ID, hence two bubbles.
  assign need_two = h_lu && ID_Branch;
  assign need_one = h_lu || h_ba || h_bm;

  // State register: only the FSM state lives here; reset always returns to RUN.
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next-state and output decode; stalls take priority over a taken-branch squash.
  always_comb begin
    state_next    = state;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    Stall         = 1'b0;
    branch_squash = 1'b0;
    if (Reset) begin
      state_next  = ST_RUN;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (need_one) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            Stall       = 1'b1;
            if (need_two) state_next = ST_STALL;
          end else if (ID_Branch && ID_Branch_Taken) begin
            IF_ID_Flush   = 1'b1;
            branch_squash = 1'b1;
          end
        end
        ST_STALL: begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
          Stall       = 1'b1;
          state_next  = ST_RUN;
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating statistics counters for stall cycles and branch squashes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (Stall && !(&Stall_Count))         Stall_Count <= Stall_Count + 1'b1;
      if (branch_squash && !(&Flush_Count)) Flush_Count <= Flush_Count + 1'b1;
    end
  end
`else
  // Squash indication is only consumed by the statistics counters.
  logic unused_squash;
  assign unused_squash = branch_squash;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed-vector scoreboard bench for hazard_unit.
// Each vector pushes its hand-computed expected outputs into a queue; a
// monitor pops and compares once per cycle on the falling edge.
module tb_hazard_unit;

  logic       Clock;
  logic       Reset;
  logic [4:0] IF_ID_RegisterRs, IF_ID_RegisterRt;
  logic       ID_Branch, ID_Branch_Taken;
  logic       ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegDst;
  logic [4:0] ID_EX_RegisterRt, ID_EX_RegisterRd;
  logic       EX_MEM_MemRead;
  logic [4:0] EX_MEM_RegisterRd;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Stall;
`ifdef HAZARD_STATS_EN
  logic [2:0] Stall_Count, Flush_Count;
`endif

  // Expected output word: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Stall}
  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_SQSH  = 5'b11100;
  localparam logic [4:0] O_RST   = 5'b00110;

  typedef struct {
    string      name;
    logic [4:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef HAZARD_STATS_EN
  hazard_unit #(.rwidth(5), .cwidth(3)) dut (
`else
  hazard_unit #(.rwidth(5)) dut (
`endif
    .Clock(Clock), .Reset(Reset),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .ID_Branch(ID_Branch), .ID_Branch_Taken(ID_Branch_Taken),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_RegDst(ID_EX_RegDst),
    .ID_EX_RegisterRt(ID_EX_RegisterRt), .ID_EX_RegisterRd(ID_EX_RegisterRd),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .Stall(Stall)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // One vector per cycle: drive just after the rising edge, queue the expectation.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic br, input logic tk,
                               input logic exmr, input logic exrw, input logic exrdst,
                               input logic [4:0] exrt, input logic [4:0] exrd,
                               input logic memr, input logic [4:0] memrd,
                               input logic [4:0] outs);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset            = rst;
    IF_ID_RegisterRs = rs;
    IF_ID_RegisterRt = rt;
    ID_Branch        = br;
    ID_Branch_Taken  = tk;
    ID_EX_MemRead    = exmr;
    ID_EX_RegWrite   = exrw;
    ID_EX_RegDst     = exrdst;
    ID_EX_RegisterRt = exrt;
    ID_EX_RegisterRd = exrd;
    EX_MEM_MemRead   = memr;
    EX_MEM_RegisterRd = memrd;
    e.name = name;
    e.outs = outs;
    exp_q.push_back(e);
  endtask

  task automatic idleCycle(input string name);
    applyStimulus(name, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_IDLE);
  endtask

  // Monitor: compare the combinational outputs mid-cycle against the oldest expectation.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e.name, {27'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Stall},
                  {27'd0, e.outs});
    end
  end

  initial begin
    Reset = 1'b1;
    IF_ID_RegisterRs = '0; IF_ID_RegisterRt = '0;
    ID_Branch = 0; ID_Branch_Taken = 0;
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegDst = 0;
    ID_EX_RegisterRt = '0; ID_EX_RegisterRd = '0;
    EX_MEM_MemRead = 0; EX_MEM_RegisterRd = '0;

    //               name            rst rs  rt  br tk mr rw rd exrt exrd mm mrd  outs
    applyStimulus("reset0",          1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_RST);
    applyStimulus("reset1",          1, 5'd2, 5'd0, 0, 0, 1, 0, 0, 5'd2, 5'd0, 0, 5'd0, O_RST);
    idleCycle("idle_after_reset");
    // load-use: lw $2 in EX, add using $2
    applyStimulus("lu_stall",        0, 5'd2, 5'd7, 0, 0, 1, 1, 0, 5'd2, 5'd0, 0, 5'd0, O_STALL);
    applyStimulus("lu_release",      0, 5'd2, 5'd7, 0, 0, 0, 0, 0, 5'd0, 5'd0, 1, 5'd2, O_IDLE);
    // load then branch: two bubbles, second ignores inputs
    applyStimulus("lb_stall1",       0, 5'd1, 5'd3, 1, 0, 1, 1, 0, 5'd3, 5'd0, 0, 5'd0, O_STALL);
    applyStimulus("lb_stall2",       0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_STALL);
    idleCycle("lb_release");
    // ALU result feeding a taken branch: one stall, then squash
    applyStimulus("ba_stall",        0, 5'd4, 5'd5, 1, 1, 0, 1, 1, 5'd9, 5'd4, 0, 5'd0, O_STALL);
    applyStimulus("ba_squash",       0, 5'd4, 5'd5, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd4, O_SQSH);
    idleCycle("ba_after");
    // register 0 never hazards; taken branch with no hazard squashes immediately
    applyStimulus("zero_reg",        0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, O_IDLE);
    applyStimulus("taken_nohaz",     0, 5'd8, 5'd9, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_SQSH);
    applyStimulus("taken_nonbranch", 0, 5'd8, 5'd9, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_IDLE);
    // branch on load in MEM
    applyStimulus("bm_stall",        0, 5'd6, 5'd5, 1, 0, 0, 0, 0, 5'd0, 5'd0, 1, 5'd5, O_STALL);
    applyStimulus("bm_mem_r0",       0, 5'd0, 5'd5, 1, 0, 0, 0, 0, 5'd0, 5'd0, 1, 5'd0, O_IDLE);
    // RegDst selects rt vs rd for the EX destination
    applyStimulus("ba_rt_dst",       0, 5'd6, 5'd1, 1, 0, 0, 1, 0, 5'd6, 5'd7, 0, 5'd0, O_STALL);
    applyStimulus("ba_rd_unsel",     0, 5'd7, 5'd1, 1, 0, 0, 1, 0, 5'd6, 5'd7, 0, 5'd0, O_IDLE);
    applyStimulus("ba_memread_off",  0, 5'd8, 5'd1, 1, 0, 1, 1, 1, 5'd9, 5'd8, 0, 5'd0, O_IDLE);
    applyStimulus("alu_nonbranch",   0, 5'd4, 5'd1, 0, 0, 0, 1, 1, 5'd0, 5'd4, 0, 5'd0, O_IDLE);
    applyStimulus("ba_norw",         0, 5'd4, 5'd1, 1, 0, 0, 0, 1, 5'd0, 5'd4, 0, 5'd0, O_IDLE);
    // reset aborts a two-cycle stall
    applyStimulus("rs_stall1",       0, 5'd3, 5'd1, 1, 0, 1, 1, 0, 5'd3, 5'd0, 0, 5'd0, O_STALL);
    applyStimulus("rs_reset",        1, 5'd3, 5'd1, 1, 0, 1, 1, 0, 5'd3, 5'd0, 0, 5'd0, O_RST);
    idleCycle("rs_back_to_run");

`ifdef HAZARD_STATS_EN
    applyStimulus("st_reset",        1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_RST);
    applyStimulus("st_lb1",          0, 5'd1, 5'd3, 1, 0, 1, 1, 0, 5'd3, 5'd0, 0, 5'd0, O_STALL);
    applyStimulus("st_lb2",          0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_STALL);
    applyStimulus("st_squash",       0, 5'd8, 5'd9, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_SQSH);
    idleCycle("st_idle");
    #1;
    checkOutput("stall_count", {29'd0, Stall_Count}, 32'd2);
    checkOutput("flush_count", {29'd0, Flush_Count}, 32'd1);
    for (int i = 0; i < 6; i++)
      applyStimulus("st_more_stall", 0, 5'd2, 5'd0, 0, 0, 1, 1, 0, 5'd2, 5'd0, 0, 5'd0, O_STALL);
    for (int i = 0; i < 7; i++)
      applyStimulus("st_more_sqsh",  0, 5'd8, 5'd9, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, O_SQSH);
    idleCycle("st_sat_idle");
    #1;
    checkOutput("stall_count_sat", {29'd0, Stall_Count}, 32'd7);
    checkOutput("flush_count_sat", {29'd0, Flush_Count}, 32'd7);
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
